// File: rtl/gcd_engine.sv
// Iterative binary (Stein) GCD engine: one reduction step per clock, optional
// constant-time padding to 2*WIDTH iterations, illegal opcodes complete at once.
module gcd_engine #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             START_PULSE,
  input  logic [2:0]       OPCODE,
  input  logic             CONSTANT_TIME,
  input  logic [WIDTH-1:0] OPERAND_A,
  input  logic [WIDTH-1:0] OPERAND_B,
  output logic [WIDTH-1:0] RESULT,
  output logic [11:0]      CYCLE_COUNT,
  output logic             DONE_PULSE,
  output logic             BUSY,
  output logic             ERROR
);

  localparam int              KW       = $clog2(WIDTH + 1);
  localparam logic [11:0]     ITER_MAX = 12'(2 * WIDTH);
  localparam logic [KW-1:0]   K_ONE    = KW'(1);
  localparam logic [WIDTH-1:0] W_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [11:0]      iter_q, iter_d;
  logic             coprime_q, coprime_d;
  logic             ct_q, ct_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [11:0]      cycle_count_q, cycle_count_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;

  logic             term_s;
  logic [WIDTH-1:0] gcd_s;
  logic [WIDTH-1:0] a_diff_s;
  logic [WIDTH-1:0] b_diff_s;

  // Next-state, datapath step and completion logic.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    k_d           = k_q;
    iter_d        = iter_q;
    coprime_d     = coprime_q;
    ct_d          = ct_q;
    result_d      = result_q;
    cycle_count_d = cycle_count_q;
    done_d        = 1'b0;
    error_d       = error_q;

    term_s   = (a_q == W_ZERO) || (b_q == W_ZERO);
    gcd_s    = (a_q | b_q) << k_q;
    // Only the larger-minus-smaller difference is ever selected, so no underflow.
    a_diff_s = a_q - b_q;
    b_diff_s = b_q - a_q;

    case (state_q)
      S_IDLE: begin
        if (START_PULSE) begin
          a_d       = OPERAND_A;
          b_d       = OPERAND_B;
          k_d       = {KW{1'b0}};
          iter_d    = 12'd0;
          coprime_d = (OPCODE == 3'b001);
          ct_d      = CONSTANT_TIME;
          error_d   = 1'b0;
          if (OPCODE > 3'b001) begin
            result_d      = W_ZERO;
            cycle_count_d = 12'd0;
            done_d        = 1'b1;
            error_d       = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (term_s && (!ct_q || (iter_q == ITER_MAX))) begin
          result_d      = coprime_q ? ((gcd_s == W_ONE) ? W_ONE : W_ZERO) : gcd_s;
          cycle_count_d = iter_q;
          done_d        = 1'b1;
          state_d       = S_IDLE;
        end else begin
          // Padding cycles (term already true) only advance iter.
          if (!term_s) begin
            if (!a_q[0] && !b_q[0]) begin
              a_d = a_q >> 1;
              b_d = b_q >> 1;
              k_d = k_q + K_ONE;
            end else if (!a_q[0]) begin
              a_d = a_q >> 1;
            end else if (!b_q[0]) begin
              b_d = b_q >> 1;
            end else if (a_q >= b_q) begin
              a_d = a_diff_s >> 1;
            end else begin
              b_d = b_diff_s >> 1;
            end
          end else begin
            a_d = a_q;
          end
          iter_d = iter_q + 12'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= S_IDLE;
      a_q           <= {WIDTH{1'b0}};
      b_q           <= {WIDTH{1'b0}};
      k_q           <= {KW{1'b0}};
      iter_q        <= 12'd0;
      coprime_q     <= 1'b0;
      ct_q          <= 1'b0;
      result_q      <= {WIDTH{1'b0}};
      cycle_count_q <= 12'd0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      k_q           <= k_d;
      iter_q        <= iter_d;
      coprime_q     <= coprime_d;
      ct_q          <= ct_d;
      result_q      <= result_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
    end
  end

  assign RESULT      = result_q;
  assign CYCLE_COUNT = cycle_count_q;
  assign DONE_PULSE  = done_q;
  assign BUSY        = busy_q;
  assign ERROR       = error_q;

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Iterative binary (Stein) GCD datapath and sequencer. It sits directly downstream of the APB control register file: it consumes `START_PULSE`, `OPCODE` and `CONSTANT_TIME`, and returns `DONE_PULSE` and `CYCLE_COUNT` to that block for status/IRQ capture. It computes one reduction step per clock. An optional constant-time mode pads every run to a fixed, data-independent iteration count.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Legal range 4..1024, so that 2*WIDTH fits in 12 bits.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESETn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `START_PULSE`  in  1  one-cycle start request.
- `OPCODE`  in  3  operation select, sampled on an accepted start.
- `CONSTANT_TIME`  in  1  constant-time mode select, sampled on an accepted start.
- `OPERAND_A`  in  WIDTH  first operand, sampled on an accepted start.
- `OPERAND_B`  in  WIDTH  second operand, sampled on an accepted start.
- `RESULT`  out  WIDTH  result of the last completed operation.
- `CYCLE_COUNT`  out  12  number of RUN iterations executed by the last operation.
- `DONE_PULSE`  out  1  one-cycle completion strobe.
- `BUSY`  out  1  high while an operation is in progress.
- `ERROR`  out  1  high if the last operation used an illegal opcode.

## Operation
- Opcodes:
  - 3'b000: GCD. `RESULT` = gcd(A,B).
  - 3'b001: COPRIME. `RESULT` = {0…, gcd==1}.
  - 3'b010–3'b111: illegal. Complete immediately with `ERROR`=1, `RESULT`=0, `CYCLE_COUNT`=0.
- States are IDLE and RUN. `BUSY` = (state==RUN).
- IDLE with `START_PULSE`=1:
  - Latch a=`OPERAND_A`, b=`OPERAND_B`, k=0, iter=0, and the opcode and CT bit.
  - Clear `ERROR`.
  - Go to RUN. For an illegal opcode, complete instead (see below) and stay in IDLE.
- `START_PULSE` is ignored while in RUN.
- Terminated condition: term = (a==0) || (b==0).
- RUN, on each edge:
  - If term and (CT==0 or iter==2*WIDTH): complete.
  - Otherwise, if !term, apply exactly one step, in priority order:
    - a and b both even: a>>=1, b>>=1, k+=1.
    - a even: a>>=1.
    - b even: b>>=1.
    - both odd and a>=b: a=(a−b)>>1.
    - both odd and a<b: b=(b−a)>>1.
  - If term (CT padding cycle): a, b and k hold.
  - In both cases iter+=1.
- Complete, in one edge:
  - `RESULT` <= (a|b)<<k, or the coprime bit for opcode 3'b001.
  - `CYCLE_COUNT` <= iter.
  - `DONE_PULSE` <= 1.
  - State <= IDLE.
- Width rules:
  - Subtraction is WIDTH bits and never underflows, because of the ordering above.
  - k is clog2(WIDTH+1) bits.
  - iter is 12 bits.
  - (a|b)<<k never exceeds WIDTH bits for legal inputs.
- Zero operands: gcd(0,0)=0 and gcd(0,x)=x. Term is true at the first RUN edge.
- Step bound: each step removes at least one bit from a or b, so at most 2*WIDTH steps occur. In CT mode iter always equals 2*WIDTH at completion.
- `RESULT`, `CYCLE_COUNT` and `ERROR` hold until the next completion. `ERROR` is cleared on every accepted start.
- Reset values: state IDLE; `RESULT`=0, `CYCLE_COUNT`=0, `DONE_PULSE`=0, `BUSY`=0, `ERROR`=0; internal a, b, k and iter all 0.

## Timing
- Start edge E0 samples the start; `BUSY` is high from E0 to the completion edge.
- Variable-time latency:
  - With n steps, steps occur at edges E1..En and completion at E(n+1).
  - `DONE_PULSE` is high for exactly the one cycle following E(n+1).
  - `CYCLE_COUNT`=n.
- Constant-time latency: completion at E(2*WIDTH+1), `CYCLE_COUNT`=2*WIDTH, independent of the data.
- Illegal opcode: completion at E0, so `DONE_PULSE` is high in the cycle after E0 and `BUSY` never asserts.
- A new start is accepted in the same cycle that `DONE_PULSE` is high, since the state is already IDLE.
- Reset asserted mid-RUN:
  - All outputs return to their reset values immediately.
  - No `DONE_PULSE` is produced.
  - After reset release, the block waits in IDLE for a fresh start.

## Test plan
- GCD, A=12, B=18, CT=0 → 4 steps; `DONE_PULSE` one cycle after E5; `RESULT`=6, `CYCLE_COUNT`=4, `ERROR`=0.
- Same operands with CT=1, WIDTH=32 → `DONE_PULSE` after E65; `RESULT`=6, `CYCLE_COUNT`=64. Then A=1, B=0xFFFFFFFF with CT=1 → `CYCLE_COUNT` is again 64.
- Zero operands, CT=0:
  - A=0, B=0 → `RESULT`=0, `CYCLE_COUNT`=0, `DONE_PULSE` after E1.
  - A=0, B=7 → `RESULT`=7.
- COPRIME, CT=0:
  - A=35, B=64 → `RESULT`=1.
  - A=21, B=14 → `RESULT`=0.
- Illegal opcode 3'b101 → `DONE_PULSE` in the cycle after E0; `ERROR`=1, `RESULT`=0, `CYCLE_COUNT`=0, `BUSY` stays 0. The next legal start clears `ERROR`.
- Protection and reset:
  - A second `START_PULSE` at E2 of a running GCD is ignored, and the original result is unchanged.
  - `RESETn` pulled low at E3 of a run → all outputs reset immediately and no `DONE_PULSE` follows.
